// File: rtl/selector41_scanner.sv
// -----------------------------------------------------------------------------
// selector41_scanner
//
// Drives the select lines of a 4-to-1 selector41 mux. On a start request the
// mux is stepped through channels 0..3. Each channel is held for DWELL cycles,
// and the mux output is captured into that channel's register on the last
// dwell cycle. A one-cycle done pulse follows the capture of channel 3, so
// all four channel values are then available in parallel, registered.
//
// Parameters:
//   WIDTH  data width of iZ and of each capture register (default 4)
//   DWELL  cycles each select value is held, legal range 1..15 (default 3)
//
// Ports:
//   iClk    in   1      system clock, rising edge
//   iRst    in   1      synchronous, active-high reset
//   iStart  in   1      scan request, sampled only in IDLE
//   iAbort  in   1      abort a running scan, sampled only in SCAN
//   iZ      in   WIDTH  mux output (selector41 oZ)
//   oS0     out  1      mux select LSB (registered)
//   oS1     out  1      mux select MSB (registered)
//   oD0..3  out  WIDTH  captured channel values
//   oBusy   out  1      high while scanning
//   oChg    out  4      per-channel "value changed at last capture" flags
//                       (present only with SELECTOR41_SCANNER_CHG_EN defined)
//   oDone   out  1      one-cycle pulse after channel 3 is captured
//
// Build option:
//   SELECTOR41_SCANNER_CHG_EN  adds the oChg port and its change tracking.
// -----------------------------------------------------------------------------
module selector41_scanner #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DWELL = 3
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iStart,
   input  logic             iAbort,
   input  logic [WIDTH-1:0] iZ,
   output logic             oS0,
   output logic             oS1,
   output logic [WIDTH-1:0] oD0,
   output logic [WIDTH-1:0] oD1,
   output logic [WIDTH-1:0] oD2,
   output logic [WIDTH-1:0] oD3,
   output logic             oBusy,
`ifdef SELECTOR41_SCANNER_CHG_EN
   output logic [3:0]       oChg,
`endif
   output logic             oDone
);

   // Dwell counter width: ceil(log2(DWELL)) + 1, which is at least 1 bit
   // even for DWELL = 1.
   localparam int unsigned   CW       = $clog2(DWELL) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
   localparam logic [1:0]    CH_LAST  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       ch_q,    ch_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0] d_q [4];
   logic [WIDTH-1:0] d_d [4];
   logic             cap_en;
   logic             dwell_end;

`ifdef SELECTOR41_SCANNER_CHG_EN
   logic [3:0]       chg_q, chg_d;
`endif

   assign dwell_end = (cnt_q == CNT_LAST);

   // --------------------------------------------------------------------------
   // State register (FSM state plus channel / dwell counters)
   // --------------------------------------------------------------------------
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         ch_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cnt_d   = cnt_q;
      cap_en  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (iStart) begin
               state_d = SCAN;
               ch_d    = '0;
               cnt_d   = '0;
            end
         end

         SCAN: begin
            if (!dwell_end) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cap_en = 1'b1;
               cnt_d  = '0;
               if (ch_q == CH_LAST) begin
                  state_d = DONE;
                  ch_d    = '0;
               end else begin
                  ch_d = ch_q + 2'd1;
               end
            end
            // Abort overrides the sequencing but not the capture: a capture
            // due on this same edge still lands in its register.
            if (iAbort) begin
               state_d = IDLE;
               ch_d    = '0;
               cnt_d   = '0;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            ch_d    = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Capture registers
   // --------------------------------------------------------------------------
   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         d_d[i] = d_q[i];
      end
      if (cap_en) begin
         d_d[ch_q] = iZ;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         for (int unsigned i = 0; i < 4; i++) begin
            d_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            d_q[i] <= d_d[i];
         end
      end
   end

`ifdef SELECTOR41_SCANNER_CHG_EN
   // Change flag of a channel is rewritten at each of its captures, comparing
   // the incoming value with the value it replaces.
   always_comb begin
      chg_d = chg_q;
      if (cap_en) begin
         chg_d[ch_q] = (iZ != d_q[ch_q]);
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         chg_q <= '0;
      end else begin
         chg_q <= chg_d;
      end
   end
`endif

   // --------------------------------------------------------------------------
   // Output logic
   // --------------------------------------------------------------------------
   always_comb begin
      oS0   = ch_q[0];
      oS1   = ch_q[1];
      oD0   = d_q[0];
      oD1   = d_q[1];
      oD2   = d_q[2];
      oD3   = d_q[3];
      oBusy = (state_q == SCAN);
      oDone = (state_q == DONE);
`ifdef SELECTOR41_SCANNER_CHG_EN
      oChg  = chg_q;
`endif
   end

endmodule

// File: tb/tb_selector41_scanner.sv
// -----------------------------------------------------------------------------
// Testbench for selector41_scanner. Two instances share one clock: one with
// DWELL = 3 and one with DWELL = 1. The selector41 mux is modelled as an
// array lookup indexed by the scanner's select outputs. Expected values come
// from the scan timeline: with the start sampled at edge E0, t counts edges
// after E0; busy for t < 4*D, select = t / D, channel k captured at
// t = (k+1)*D, done at t = 4*D.
// -----------------------------------------------------------------------------
module tb_selector41_scanner;

   localparam int D3 = 3;
   localparam int D1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // DWELL = 3 instance
   logic       rst3, start3, abort3, s0_3, s1_3, busy3, done3;
   logic [3:0] z3;
   logic [3:0] od3    [4];
   logic [3:0] c3     [4];
   logic [3:0] exp_d3 [4];
   logic [3:0] exp_chg3;

   // DWELL = 1 instance
   logic       rst1, start1, abort1, s0_1, s1_1, busy1, done1;
   logic [3:0] z1;
   logic [3:0] od1    [4];
   logic [3:0] c1     [4];
   logic [3:0] exp_d1 [4];
   logic [3:0] exp_chg1;

`ifdef SELECTOR41_SCANNER_CHG_EN
   logic [3:0] chg3, chg1;
`endif

   assign z3 = c3[{s1_3, s0_3}];
   assign z1 = c1[{s1_1, s0_1}];

   selector41_scanner #(.WIDTH(4), .DWELL(D3)) u_dut3 (
      .iClk   (clk),
      .iRst   (rst3),
      .iStart (start3),
      .iAbort (abort3),
      .iZ     (z3),
      .oS0    (s0_3),
      .oS1    (s1_3),
      .oD0    (od3[0]),
      .oD1    (od3[1]),
      .oD2    (od3[2]),
      .oD3    (od3[3]),
      .oBusy  (busy3),
`ifdef SELECTOR41_SCANNER_CHG_EN
      .oChg   (chg3),
`endif
      .oDone  (done3)
   );

   selector41_scanner #(.WIDTH(4), .DWELL(D1)) u_dut1 (
      .iClk   (clk),
      .iRst   (rst1),
      .iStart (start1),
      .iAbort (abort1),
      .iZ     (z1),
      .oS0    (s0_1),
      .oS1    (s1_1),
      .oD0    (od1[0]),
      .oD1    (od1[1]),
      .oD2    (od1[2]),
      .oD3    (od1[3]),
      .oBusy  (busy1),
`ifdef SELECTOR41_SCANNER_CHG_EN
      .oChg   (chg1),
`endif
      .oDone  (done1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check3(input string tag, input bit busy, input bit done, input int sel);
      chk({tag, " busy3"}, 32'(busy3), 32'(busy));
      chk({tag, " done3"}, 32'(done3), 32'(done));
      chk({tag, " sel3"},  32'({s1_3, s0_3}), 32'(sel));
      for (int k = 0; k < 4; k++)
         chk($sformatf("%s oD%0d_3", tag, k), 32'(od3[k]), 32'(exp_d3[k]));
`ifdef SELECTOR41_SCANNER_CHG_EN
      chk({tag, " chg3"}, 32'(chg3), 32'(exp_chg3));
`endif
   endtask

   task automatic check1(input string tag, input bit busy, input bit done, input int sel);
      chk({tag, " busy1"}, 32'(busy1), 32'(busy));
      chk({tag, " done1"}, 32'(done1), 32'(done));
      chk({tag, " sel1"},  32'({s1_1, s0_1}), 32'(sel));
      for (int k = 0; k < 4; k++)
         chk($sformatf("%s oD%0d_1", tag, k), 32'(od1[k]), 32'(exp_d1[k]));
`ifdef SELECTOR41_SCANNER_CHG_EN
      chk({tag, " chg1"}, 32'(chg1), 32'(exp_chg1));
`endif
   endtask

   // Reference model of one capture: the change flag compares the new value
   // with the one it replaces.
   task automatic capture3(input int k);
      exp_chg3[k] = (c3[k] != exp_d3[k]);
      exp_d3[k]   = c3[k];
   endtask

   task automatic capture1(input int k);
      exp_chg1[k] = (c1[k] != exp_d1[k]);
      exp_d1[k]   = c1[k];
   endtask

   task automatic clear3();
      for (int k = 0; k < 4; k++) exp_d3[k] = '0;
      exp_chg3 = '0;
   endtask

   task automatic rand_c3();
      for (int k = 0; k < 4; k++) c3[k] = 4'($urandom);
   endtask

   // One scan on the DWELL = 3 instance. abort_at < 0 means no abort;
   // repulse re-asserts iStart during SCAN and during DONE.
   task automatic scan3(input int abort_at, input bit repulse);
      bit aborted = 1'b0;
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      for (int t = 0; t <= 4 * D3; t++) begin
         if (t > 0 && (t % D3) == 0) capture3(t / D3 - 1);
         if (aborted) begin
            check3("after_abort", 1'b0, 1'b0, 0);
            break;
         end
         if (t < 4 * D3) check3($sformatf("scan t%0d", t), 1'b1, 1'b0, t / D3);
         else            check3("done", 1'b0, 1'b1, 0);
         abort3  = (t == abort_at);
         start3  = repulse && (t == 4 || t == 4 * D3);
         aborted = (t == abort_at);
         step();
      end
      abort3 = 1'b0;
      start3 = 1'b0;
      check3("idle", 1'b0, 1'b0, 0);
      step();
      check3("idle2", 1'b0, 1'b0, 0);
   endtask

   initial begin
      rst3 = 1'b1; start3 = 1'b0; abort3 = 1'b0;
      rst1 = 1'b1; start1 = 1'b0; abort1 = 1'b0;
      c3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      c1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      clear3();
      for (int k = 0; k < 4; k++) exp_d1[k] = '0;
      exp_chg1 = '0;

      // Reset state
      step();
      step();
      check3("reset", 1'b0, 1'b0, 0);
      check1("reset", 1'b0, 1'b0, 0);
      rst3 = 1'b0;
      rst1 = 1'b0;
      step();
      check3("post_reset", 1'b0, 1'b0, 0);

      // Plain scan with one-hot channel values
      scan3(-1, 1'b0);

      // Start re-pulsed during SCAN and DONE has no effect
      rand_c3();
      scan3(-1, 1'b1);

      // Abort on channel 1 mid-dwell after reset cleared the captures
      rst3 = 1'b1;
      step();
      rst3 = 1'b0;
      clear3();
      check3("reset2", 1'b0, 1'b0, 0);
      c3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      scan3(4, 1'b0);

      // Reset in the middle of a scan, then a normal scan
      rand_c3();
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      repeat (4) step();
      capture3(0);
      check3("pre_rst_mid", 1'b1, 1'b0, 1);
      rst3 = 1'b1;
      step();
      rst3 = 1'b0;
      clear3();
      check3("rst_mid", 1'b0, 1'b0, 0);
      rand_c3();
      scan3(-1, 1'b0);

      // Randomized scans, some with random abort points
      repeat (3) begin
         rand_c3();
         scan3(-1, 1'b0);
      end
      repeat (4) begin
         rand_c3();
         scan3(int'($urandom_range(0, 4 * D3 - 1)), 1'b0);
      end

      // DWELL = 1 with iStart held high: back-to-back scans, period 6
      start1 = 1'b1;
      step();
      for (int s = 0; s < 4; s++) begin
         for (int t = 0; t <= 5; t++) begin
            if (t >= 1 && t <= 4) capture1(t - 1);
            if (t < 4)       check1($sformatf("d1 s%0d t%0d", s, t), 1'b1, 1'b0, t);
            else if (t == 4) check1($sformatf("d1 s%0d done", s), 1'b0, 1'b1, 0);
            else             check1($sformatf("d1 s%0d gap", s), 1'b0, 1'b0, 0);
            if (t == 5) begin
`ifdef SELECTOR41_SCANNER_CHG_EN
               if (s == 0) chk("chg_scan1", 32'(chg1), 32'(4'b1111));
               if (s == 1) chk("chg_scan2", 32'(chg1), 32'(4'b0100));
               if (s == 2) chk("chg_scan3", 32'(chg1), 32'(4'b0000));
`endif
               if (s == 0) c1[2] = 4'b0111;
               if (s == 2) for (int k = 0; k < 4; k++) c1[k] = 4'($urandom);
               if (s == 3) start1 = 1'b0;
            end
            step();
         end
      end
      check1("d1 idle", 1'b0, 1'b0, 0);
      step();
      check1("d1 idle2", 1'b0, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
